// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and types for the pipeline controller: stall/flush
// encodings, exception codes and the redirect FSM state type.
package pipeline_ctrl_pkg;

   localparam logic STOP                     = 1'b1;
   localparam logic NO_STOP                  = 1'b0;
   localparam logic FLUSH                    = 1'b1;
   localparam logic NO_FLUSH                 = 1'b0;
   localparam logic FAILED_BRANCH_PREDICTION = 1'b0;
   localparam logic EXCEPTION                = 1'b1;

   localparam logic [31:0] EXC_TYPE_ERET = 32'h0000_000E;
   localparam logic [31:0] EXC_VECTOR    = 32'hBFC0_0380;

   localparam int STALL_W = 6;

   // pc and if stages held while a redirect waits for the icache
   localparam logic [STALL_W-1:0] PEND_STALL_MASK = {NO_STOP, NO_STOP, NO_STOP, NO_STOP, STOP, STOP};

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_PEND = 1'b1
   } ctrl_state_e;

   // Highest requesting stage wins; it and every stage before it stop.
   function automatic logic [STALL_W-1:0] stall_vector(input logic if_req,
                                                       input logic id_req,
                                                       input logic ex_req,
                                                       input logic mem_req);
      logic [STALL_W-1:0] v;
      if (mem_req)     v = {NO_STOP, STOP,    STOP,    STOP,    STOP, STOP};
      else if (ex_req) v = {NO_STOP, NO_STOP, STOP,    STOP,    STOP, STOP};
      else if (id_req) v = {NO_STOP, NO_STOP, NO_STOP, STOP,    STOP, STOP};
      else if (if_req) v = {NO_STOP, NO_STOP, NO_STOP, NO_STOP, STOP, STOP};
      else             v = {STALL_W{NO_STOP}};
      return v;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_counter.sv
// Saturating 32-bit event counter with enable.
module stall_counter
   import pipeline_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        en_i,
   output logic [31:0] count_o
);

   logic [31:0] count_q;
   logic [31:0] count_d;

   // Next count: step when enabled, hold once all ones.
   always_comb begin
      // NOTE: default first so every path assigns count_d and no latch is inferred.
      count_d = count_q;
      if (en_i && (count_q != 32'hFFFF_FFFF)) begin
         count_d = count_q + 32'd1;
      end
   end

   // Counter register, cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      if (!resetn) count_q <= '0;
      else         count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/flush controller: combinational stall vector, flush on
// exception or mispredict, and a redirect that is deferred while the icache
// is busy.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               resetn,
   input  logic               stallreq_if_i,
   input  logic               stallreq_id_i,
   input  logic               stallreq_ex_i,
   input  logic               stallreq_mem_i,
   input  logic               exc_valid_i,
   input  logic [31:0]        exc_type_i,
   input  logic [31:0]        cp0_epc_i,
   input  logic               mispredict_i,
   input  logic [31:0]        branch_target_i,
   output logic [STALL_W-1:0] stall_o,
   output logic               flush_o,
   output logic               flush_cause_o,
   output logic               redirect_o,
   output logic [31:0]        redirect_pc_o,
   output logic [31:0]        stall_cycles_o
);

   ctrl_state_e  state_q, state_d;
   logic [31:0]  pend_pc_q, pend_pc_d;

   logic [STALL_W-1:0] stall_c;
   logic               flush_c;
   logic               cause_c;
   logic               redirect_c;
   logic [31:0]        redirect_pc_c;
   logic [31:0]        flush_target;
   logic [STALL_W-1:0] req_stall;

   // Exception target beats branch target; eret returns to EPC.
   always_comb begin
      if (exc_valid_i) flush_target = (exc_type_i == EXC_TYPE_ERET) ? cp0_epc_i : EXC_VECTOR;
      else             flush_target = branch_target_i;
      req_stall = stall_vector(stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i);
   end

   // Next-state and output decode; a flush event suppresses stall requests.
   always_comb begin
      state_d       = state_q;
      pend_pc_d     = pend_pc_q;
      stall_c       = {STALL_W{NO_STOP}};
      flush_c       = NO_FLUSH;
      cause_c       = FAILED_BRANCH_PREDICTION;
      redirect_c    = 1'b0;
      redirect_pc_c = 32'h0;
      case (state_q)
         ST_RUN: begin
            if (exc_valid_i || mispredict_i) begin
               flush_c = FLUSH;
               cause_c = exc_valid_i ? EXCEPTION : FAILED_BRANCH_PREDICTION;
               if (stallreq_if_i) begin
                  // icache cannot take the new pc yet: park it
                  pend_pc_d = flush_target;
                  state_d   = ST_PEND;
               end else begin
                  redirect_c    = 1'b1;
                  redirect_pc_c = flush_target;
               end
            end else begin
               stall_c = req_stall;
            end
         end
         ST_PEND: begin
            if (exc_valid_i) begin
               // a newer exception replaces the parked target
               flush_c   = FLUSH;
               cause_c   = EXCEPTION;
               pend_pc_d = flush_target;
               stall_c   = PEND_STALL_MASK;
            end else begin
               // mispredicts are stale here: the younger instructions are gone
               stall_c = req_stall | PEND_STALL_MASK;
               if (!stallreq_if_i) begin
                  redirect_c    = 1'b1;
                  redirect_pc_c = pend_pc_q;
                  state_d       = ST_RUN;
               end
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Outputs are held quiet while reset is asserted.
   always_comb begin
      stall_o       = resetn ? stall_c       : {STALL_W{NO_STOP}};
      flush_o       = resetn ? flush_c       : NO_FLUSH;
      flush_cause_o = resetn ? cause_c       : FAILED_BRANCH_PREDICTION;
      redirect_o    = resetn ? redirect_c    : 1'b0;
      redirect_pc_o = resetn ? redirect_pc_c : 32'h0;
   end

   // FSM state and parked redirect target; reset drops any pending redirect.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= ST_RUN;
         pend_pc_q <= 32'h0;
      end else begin
         state_q   <= state_d;
         pend_pc_q <= pend_pc_d;
      end
   end

   stall_counter u_stall_counter (
      .clk     (clk),
      .resetn  (resetn),
      .en_i    (stall_o != {STALL_W{NO_STOP}}),
      .count_o (stall_cycles_o)
   );

endmodule
